// File: rtl/serv_seq_pkg.sv
// ---------------------------------------------------------------------------
// serv_seq_pkg
// Shared types and helpers for the bufreg2 sequencer (serv_bufreg2_seq).
//   state_e     : sequencer states IDLE, INIT, BUS, SHIFT, RUN, DONE
//   size_e      : data-bus access size encodings (byte, half, word)
//   sel_f       : byte-enable decode for a given size and address lsb
//   misalign_f  : misaligned-access detect (half on odd lsb, word on lsb != 0)
// ---------------------------------------------------------------------------
package serv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    BUS   = 3'd2,
    SHIFT = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Byte enables; byte/half masks are shifted by lsb and truncated to 4 bits,
  // so a half access at lsb=3 only enables lane 3.
  function automatic logic [3:0] sel_f(input logic [1:0] size, input logic [1:0] lsb);
    logic [3:0] sel;
    case (size)
      SZ_B:    sel = 4'b0001 << lsb;
      SZ_H:    sel = 4'b0011 << lsb;
      SZ_W:    sel = 4'b1111;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    case (size)
      SZ_H:    mis = lsb[0];
      SZ_W:    mis = (lsb != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/serv_bufreg2_seq_if.sv
// ---------------------------------------------------------------------------
// serv_bufreg2_seq_if
// Data-bus handshake between the bufreg2 sequencer and the memory side.
//   cyc : bus request, held until ack          (master -> slave)
//   we  : write strobe, 1 = store              (master -> slave)
//   sel : byte enables                          (master -> slave)
//   ack : transfer acknowledge                  (slave -> master)
// ---------------------------------------------------------------------------
interface serv_bufreg2_seq_if;
  logic       cyc;
  logic       we;
  logic [3:0] sel;
  logic       ack;

  modport master (output cyc, output we, output sel, input ack);
  modport slave  (input cyc, input we, input sel, output ack);
endinterface

// File: rtl/serv_seq_cnt.sv
// ---------------------------------------------------------------------------
// serv_seq_cnt
// Phase counter for the bufreg2 sequencer. Counts cycles inside a 32-bit
// phase and wraps naturally at NCYC (a power of two).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear to 0 (has priority over i_en)
//   i_en           : advance by one
//   o_last         : current value is NCYC-1
//   o_cnt_next     : value the counter takes at the next edge
// ---------------------------------------------------------------------------
module serv_seq_cnt #(
  parameter int CW   = 2,
  parameter int NCYC = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic          o_last,
  output logic [CW-1:0] o_cnt_next
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise step when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = {CW{1'b0}};
    end else if (i_en) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_last     = (cnt_q == CW'(NCYC - 1));
  assign o_cnt_next = cnt_d;

endmodule

// File: rtl/serv_bufreg2_seq.sv
// ---------------------------------------------------------------------------
// serv_bufreg2_seq
// Sequencer for the bit-serial buffer register (bufreg2). Runs one operation
// at a time: an INIT phase, then a data-bus handshake (loads/stores) or a
// wait on the shift down-counter (shifts), then a RUN phase that shifts the
// result out, and a one-cycle DONE pulse.
//
// Parameter: BITS_PER_CYCLE (1,2,4,8) datapath width per cycle.
// Build option: SERV_SEQ_MISALIGN_TRAP_EN -- when defined, misaligned
//   accesses skip the bus and raise o_misalign with o_done.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req                 start pulse (IDLE only)
//   i_mem_op/i_shift_op   operation class (mem has priority)
//   i_we, i_size,
//   i_addr_lsb            access attributes, latched with i_req
//   i_sh_done             bufreg2 shift counter wrapped
//   o_init/o_en/o_cnt_done/o_lsb/o_byte_valid/o_load   bufreg2 controls
//   o_rd_en               result shift-out phase
//   o_busy/o_done         status
//   o_misalign            trap pulse (trap build only)
//   dbus                  data-bus handshake (master side)
//
// All outputs except o_load are registered from the next-state decode so
// they line up with the state they describe. o_load must fire in the ack
// cycle itself, so it is decoded directly from the current state and ack.
// ---------------------------------------------------------------------------
module serv_bufreg2_seq
  import serv_seq_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_mem_op,
  input  logic       i_shift_op,
  input  logic       i_we,
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lsb,
  input  logic       i_sh_done,
  output logic       o_init,
  output logic       o_en,
  output logic       o_cnt_done,
  output logic [1:0] o_lsb,
  output logic       o_byte_valid,
  output logic       o_load,
  output logic       o_rd_en,
  output logic       o_busy,
  output logic       o_done,
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
  output logic       o_misalign,
`endif
  serv_bufreg2_seq_if.master dbus
);

  localparam int LB   = $clog2(BITS_PER_CYCLE);
  localparam int NCYC = 32 / BITS_PER_CYCLE;
  localparam int CW   = ((5 - LB) > 1) ? (5 - LB) : 1;

  state_e        state_q, state_d;
  logic          mem_q, mem_d;
  logic          shift_q, shift_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    lsb_q, lsb_d;

  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic          cnt_last_s;
  logic [CW-1:0] cnt_next_s;
  logic [7:0]    lane_s;

  logic          init_q, init_d;
  logic          en_q, en_d;
  logic          cnt_done_q, cnt_done_d;
  logic [1:0]    olsb_q, olsb_d;
  logic          bv_q, bv_d;
  logic          rd_en_q, rd_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cyc_q, cyc_d;
  logic          dwe_q, dwe_d;
  logic [3:0]    sel_q, sel_d;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
  logic          mis_q, mis_d;
`endif

  // The counter restarts on every state change, so each phase counts from 0.
  assign cnt_clr_s = (state_d != state_q);
  assign cnt_en_s  = (state_q == INIT) || (state_q == RUN);

  serv_seq_cnt #(
    .CW   (CW),
    .NCYC (NCYC)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (cnt_clr_s),
    .i_en       (cnt_en_s),
    .o_last     (cnt_last_s),
    .o_cnt_next (cnt_next_s)
  );

  // Next-state and operation-field latching.
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    shift_d = shift_q;
    we_d    = we_q;
    size_d  = size_q;
    lsb_d   = lsb_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d = INIT;
          mem_d   = i_mem_op;
          shift_d = i_shift_op;
          we_d    = i_we;
          size_d  = i_size;
          lsb_d   = i_addr_lsb;
        end else begin
          state_d = IDLE;
        end
      end
      INIT: begin
        if (cnt_last_s) begin
          if (mem_q) begin
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
            if (misalign_f(size_q, lsb_q)) begin
              state_d = DONE;
            end else begin
              state_d = BUS;
            end
`else
            state_d = BUS;
`endif
          end else if (shift_q) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = INIT;
        end
      end
      BUS: begin
        if (dbus.ack) begin
          state_d = we_q ? DONE : RUN;
        end else begin
          state_d = BUS;
        end
      end
      SHIFT: begin
        if (i_sh_done) begin
          state_d = RUN;
        end else begin
          state_d = SHIFT;
        end
      end
      RUN: begin
        if (cnt_last_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the upcoming state; registered below.
  always_comb begin
    init_d     = 1'b0;
    en_d       = 1'b0;
    cnt_done_d = 1'b0;
    olsb_d     = 2'b00;
    bv_d       = 1'b0;
    rd_en_d    = 1'b0;
    done_d     = 1'b0;
    cyc_d      = 1'b0;
    dwe_d      = 1'b0;
    sel_d      = 4'b0000;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
    mis_d      = 1'b0;
`endif
    busy_d     = (state_d != IDLE);
    // Byte lane reached by the INIT shift: cnt*BITS_PER_CYCLE/8.
    lane_s     = (8'(cnt_next_s) * 8'(BITS_PER_CYCLE)) >> 3;
    case (state_d)
      INIT: begin
        init_d     = 1'b1;
        en_d       = 1'b1;
        cnt_done_d = (cnt_next_s == CW'(NCYC - 1));
        bv_d       = !mem_d || (lane_s >= {6'b000000, lsb_d});
      end
      BUS: begin
        cyc_d = 1'b1;
        dwe_d = we_d;
        sel_d = sel_f(size_d, lsb_d);
      end
      RUN: begin
        en_d       = 1'b1;
        rd_en_d    = 1'b1;
        cnt_done_d = (cnt_next_s == CW'(NCYC - 1));
        olsb_d     = (mem_d && !we_d) ? lsb_d : 2'b00;
      end
      DONE: begin
        done_d = 1'b1;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
        mis_d  = mem_d && misalign_f(size_d, lsb_d);
`endif
      end
      default: begin
        init_d = 1'b0;
      end
    endcase
  end

  // State, latched fields and registered outputs; reset clears everything,
  // which also drops dbus.cyc immediately on an asynchronous abort.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      mem_q      <= 1'b0;
      shift_q    <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      lsb_q      <= 2'b00;
      init_q     <= 1'b0;
      en_q       <= 1'b0;
      cnt_done_q <= 1'b0;
      olsb_q     <= 2'b00;
      bv_q       <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cyc_q      <= 1'b0;
      dwe_q      <= 1'b0;
      sel_q      <= 4'b0000;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      shift_q    <= shift_d;
      we_q       <= we_d;
      size_q     <= size_d;
      lsb_q      <= lsb_d;
      init_q     <= init_d;
      en_q       <= en_d;
      cnt_done_q <= cnt_done_d;
      olsb_q     <= olsb_d;
      bv_q       <= bv_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cyc_q      <= cyc_d;
      dwe_q      <= dwe_d;
      sel_q      <= sel_d;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  assign o_init       = init_q;
  assign o_en         = en_q;
  assign o_cnt_done   = cnt_done_q;
  assign o_lsb        = olsb_q;
  assign o_byte_valid = bv_q;
  assign o_rd_en      = rd_en_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_load       = (state_q == BUS) && dbus.ack && !we_q;
  assign dbus.cyc     = cyc_q;
  assign dbus.we      = dwe_q;
  assign dbus.sel     = sel_q;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
  assign o_misalign   = mis_q;
`endif

endmodule

// File: tb/tb_serv_bufreg2_seq.sv
// ---------------------------------------------------------------------------
// tb_serv_bufreg2_seq
// Self-checking bench for serv_bufreg2_seq (BITS_PER_CYCLE=8). Each operation
// is expanded into a list of phases (INIT x NCYC, BUS x W, SHIFT x S,
// RUN x NCYC, DONE) and the expected outputs of every cycle are derived from
// the phase and its index. Inputs are sampled-away: driven at negedge, outputs
// checked 1 time unit later. Also honours SERV_SEQ_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_serv_bufreg2_seq;

  localparam int BPC  = 8;
  localparam int NCYC = 32 / BPC;

  localparam int P_IDLE  = 0;
  localparam int P_INIT  = 1;
  localparam int P_BUS   = 2;
  localparam int P_SHIFT = 3;
  localparam int P_RUN   = 4;
  localparam int P_DONE  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, mem_op = 1'b0, shift_op = 1'b0, we = 1'b0, sh_done = 1'b0;
  logic [1:0] size = 2'd0, addr_lsb = 2'd0;
  logic       o_init, o_en, o_cnt_done, o_byte_valid, o_load, o_rd_en, o_busy, o_done;
  logic [1:0] o_lsb;
  logic       mis_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_bufreg2_seq_if dbus_if ();

  serv_bufreg2_seq #(.BITS_PER_CYCLE(BPC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_mem_op     (mem_op),
    .i_shift_op   (shift_op),
    .i_we         (we),
    .i_size       (size),
    .i_addr_lsb   (addr_lsb),
    .i_sh_done    (sh_done),
    .o_init       (o_init),
    .o_en         (o_en),
    .o_cnt_done   (o_cnt_done),
    .o_lsb        (o_lsb),
    .o_byte_valid (o_byte_valid),
    .o_load       (o_load),
    .o_rd_en      (o_rd_en),
    .o_busy       (o_busy),
    .o_done       (o_done),
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
    .o_misalign   (mis_s),
`endif
    .dbus         (dbus_if)
  );

`ifndef SERV_SEQ_MISALIGN_TRAP_EN
  assign mis_s = 1'b0;
`endif

  function automatic logic [16:0] obs_f();
    return {o_init, o_en, o_cnt_done, o_lsb, o_byte_valid, o_load,
            dbus_if.cyc, dbus_if.we, dbus_if.sel, o_rd_en, o_busy, o_done, mis_s};
  endfunction

  // Expected outputs for cycle i of phase ph of an operation.
  function automatic logic [16:0] exp_f(input int ph, input int i, input bit m, input bit w,
                                        input int sz, input int lsb, input int wt, input bit mis);
    logic init, en, cd, bv, ld, cyc, wev, rd, busy, dn, mi;
    logic [1:0] ls;
    logic [3:0] sel;
    int s;
    {init, en, cd, bv, ld, cyc, wev, rd, dn, mi} = 10'd0;
    ls = 2'd0; sel = 4'd0;
    busy = (ph != P_IDLE);
    case (ph)
      P_INIT: begin
        init = 1'b1; en = 1'b1; cd = (i == NCYC - 1);
        bv = !m || ((i * BPC) / 8 >= lsb);
      end
      P_BUS: begin
        cyc = 1'b1; wev = w;
        s = (sz == 0) ? (1 << lsb) : (sz == 1) ? ((3 << lsb) & 15) : 15;
        sel = s[3:0];
        ld = !w && (i == wt - 1);
      end
      P_RUN: begin
        en = 1'b1; rd = 1'b1; cd = (i == NCYC - 1);
        ls = (m && !w) ? 2'(lsb) : 2'd0;
      end
      P_DONE: begin
        dn = 1'b1; mi = mis;
      end
      default: ;
    endcase
    return {init, en, cd, ls, bv, ld, cyc, wev, sel, rd, busy, dn, mi};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    logic [16:0] o;
    o = obs_f();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, exp);
    end
  endtask

  task automatic drive_random_fields();
    mem_op = 1'($urandom); shift_op = 1'($urandom); we = 1'($urandom);
    size = 2'($urandom); addr_lsb = 2'($urandom);
  endtask

  task automatic run_op(input bit m, input bit sh, input bit w, input int sz,
                        input int lsb, input int wt, input int s_cyc);
    int ph[$];
    int ix[$];
    bit mis;
    mis = 1'b0;
`ifdef SERV_SEQ_MISALIGN_TRAP_EN
    mis = m && ((sz == 1 && (lsb % 2) == 1) || (sz == 2 && lsb != 0));
`endif
    for (int i = 0; i < NCYC; i++) begin ph.push_back(P_INIT); ix.push_back(i); end
    if (m && !mis) begin
      for (int i = 0; i < wt; i++) begin ph.push_back(P_BUS); ix.push_back(i); end
      if (!w) for (int i = 0; i < NCYC; i++) begin ph.push_back(P_RUN); ix.push_back(i); end
    end else if (!m && sh) begin
      for (int i = 0; i < s_cyc; i++) begin ph.push_back(P_SHIFT); ix.push_back(i); end
      for (int i = 0; i < NCYC; i++) begin ph.push_back(P_RUN); ix.push_back(i); end
    end
    ph.push_back(P_DONE); ix.push_back(0);
    ph.push_back(P_IDLE); ix.push_back(0);

    @(negedge clk);
    req = 1'b1; mem_op = m; shift_op = sh; we = w; size = 2'(sz); addr_lsb = 2'(lsb);
    dbus_if.ack = 1'($urandom); sh_done = 1'($urandom);
    #1 chk("idle_req", 17'd0);
    for (int k = 0; k < ph.size(); k++) begin
      @(negedge clk);
      req = (ph[k] == P_IDLE) ? 1'b0 : 1'($urandom);
      drive_random_fields();
      dbus_if.ack = (ph[k] == P_BUS) ? (ix[k] == wt - 1) : 1'($urandom);
      sh_done = (ph[k] == P_SHIFT) ? (ix[k] == s_cyc - 1) : 1'($urandom);
      #1 chk($sformatf("ph%0d_i%0d", ph[k], ix[k]), exp_f(ph[k], ix[k], m, w, sz, lsb, wt, mis));
    end
  endtask

  initial begin
    dbus_if.ack = 1'b0;
    // Reset state.
    repeat (3) @(negedge clk);
    #1 chk("reset", 17'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain op: INIT then DONE.
    run_op(1'b0, 1'b0, 1'b0, 0, 0, 1, 1);
    // Store byte lsb=2, ack on the 3rd bus cycle.
    run_op(1'b1, 1'b0, 1'b1, 0, 2, 3, 1);
    // Load word lsb=0, ack on the 1st bus cycle.
    run_op(1'b1, 1'b0, 1'b0, 2, 0, 1, 1);
    // Shift with sh_done low 5 cycles, then high.
    run_op(1'b0, 1'b1, 1'b0, 0, 0, 1, 6);
    // Shift with sh_done already high on entry.
    run_op(1'b0, 1'b1, 1'b0, 0, 0, 1, 1);
    // Half access at lsb=1 (misaligned) and lsb=3 (truncated enables).
    run_op(1'b1, 1'b0, 1'b0, 1, 1, 2, 1);
    run_op(1'b1, 1'b0, 1'b1, 1, 3, 1, 1);
    // mem_op takes priority over shift_op.
    run_op(1'b1, 1'b1, 1'b0, 0, 3, 2, 1);

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    req = 1'b1; mem_op = 1'b1; shift_op = 1'b0; we = 1'b1; size = 2'd2; addr_lsb = 2'd0;
    dbus_if.ack = 1'b0;
    repeat (NCYC + 1) begin
      @(negedge clk);
      req = 1'b0; dbus_if.ack = 1'b0;
    end
    #1 chk("bus_before_rst", exp_f(P_BUS, 0, 1'b1, 1'b1, 2, 0, 9, 1'b0));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_no_done", 17'd0);
    @(negedge clk);
    #1 chk("rst_idle", 17'd0);
    run_op(1'b1, 1'b0, 1'b0, 0, 1, 2, 1);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
